// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: owner encoding, read-tag type and saturating counter helper for ram_port_arbiter
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BOOT = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_AUX  = 2'd3
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] c, input logic inc);
    return c + 16'(inc && c != 16'hFFFF);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-stage shift register carrying {valid, owner} of each issued RAM read
import ram_arb_pkg::*;

module rd_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [DEPTH-1:0] tag_q, tag_d;

  // Shift the new tag in at stage 0; the last stage lines up with RAM read data
  always_comb begin
    tag_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) tag_d[i] = tag_q[i-1];
    tag_out = tag_q[DEPTH-1];
  end

  // Stage registers; reset drops every in-flight read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tag_q <= '0;
    else        tag_q <= tag_d;

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: boot/CPU/aux arbiter for the work RAM with aux anti-starvation and tagged read return; ARB_STATS_EN adds grant statistics
import ram_arb_pkg::*;

module ram_port_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 8,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_mode,
  input  logic              boot_req,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic [DATA_W-1:0] boot_wdata,
  output logic              boot_gnt,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_cpu_grants,
  output logic [15:0]       stat_aux_grants,
  output logic [15:0]       stat_aux_forced
`endif
);

  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  logic [7:0]        starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              force_aux;
  tag_t              tag_in, tag_out;

  // Pick the winner, drive the RAM command from it and advance the aux starve counter
  always_comb begin
    force_aux    = rst_n && !boot_mode && aux_req && starve_cnt_q == LIM;
    boot_gnt     = rst_n && boot_mode && boot_req;
    cpu_gnt      = rst_n && !boot_mode && cpu_req && !force_aux;
    aux_gnt      = rst_n && !boot_mode && aux_req && (force_aux || !cpu_req);
    ram_we       = boot_gnt || (cpu_gnt && cpu_we) || (aux_gnt && aux_we);
    ram_re       = (cpu_gnt && !cpu_we) || (aux_gnt && !aux_we);
    addr_d       = boot_gnt ? boot_addr : cpu_gnt ? cpu_addr : aux_gnt ? aux_addr : addr_q;
    wdata_d      = boot_gnt ? boot_wdata : cpu_gnt ? cpu_wdata : aux_gnt ? aux_wdata : wdata_q;
    ram_addr     = addr_d;
    ram_wdata    = wdata_d;
    starve_cnt_d = (aux_req && !aux_gnt) ? starve_cnt_q + {7'd0, starve_cnt_q != LIM} : 8'd0;
    tag_in.valid = ram_re;
    tag_in.owner = !ram_re ? OWN_NONE : cpu_gnt ? OWN_CPU : OWN_AUX;
  end

  rd_tag_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_tags (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  // Route an exiting tag to its owner; read data is passed through and captured for holding
  always_comb begin
    cpu_rvalid = tag_out.valid && tag_out.owner == OWN_CPU;
    aux_rvalid = tag_out.valid && tag_out.owner == OWN_AUX;
    rdata_d    = tag_out.valid ? ram_rdata : rdata_q;
    rdata      = rdata_d;
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end

`ifdef ARB_STATS_EN
  logic [15:0] cpu_cnt_q, cpu_cnt_d;
  logic [15:0] aux_cnt_q, aux_cnt_d;
  logic [15:0] frc_cnt_q, frc_cnt_d;

  // Saturating grant statistics with synchronous clear
  always_comb begin
    cpu_cnt_d       = stat_clr ? 16'd0 : sat_inc16(cpu_cnt_q, cpu_gnt);
    aux_cnt_d       = stat_clr ? 16'd0 : sat_inc16(aux_cnt_q, aux_gnt);
    frc_cnt_d       = stat_clr ? 16'd0 : sat_inc16(frc_cnt_q, aux_gnt && force_aux);
    stat_cpu_grants = cpu_cnt_q;
    stat_aux_grants = aux_cnt_q;
    stat_aux_forced = frc_cnt_q;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cpu_cnt_q <= '0;
      aux_cnt_q <= '0;
      frc_cnt_q <= '0;
    end else begin
      cpu_cnt_q <= cpu_cnt_d;
      aux_cnt_q <= aux_cnt_d;
      frc_cnt_q <= frc_cnt_d;
    end
`endif

endmodule
